// File: rtl/i2s_capture_ctrl_pkg.sv
// Shared audio-path definitions: capture states, default sizes, width helper.
package i2s_capture_ctrl_pkg;

  // Defaults shared with the I2S receiver and the FFT/FIR loader.
  localparam int unsigned AUDIO_DATA_WIDTH = 16;
  localparam int unsigned AUDIO_BLOCK_LEN  = 1024;
  localparam int unsigned AUDIO_FIFO_DEPTH = 4;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_WAIT_L = 2'd3
  } cap_state_e;

  // Index width for a power-of-two count; never narrower than one bit.
  function automatic int unsigned log2w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_capture_ctrl_if.sv
// Stereo frame stream towards the FFT/FIR loader (valid/ready).
//   master: drives m_data_l, m_data_r, m_last, m_valid; receives m_ready.
//   slave : the loader side.
interface i2s_capture_ctrl_if
  import i2s_capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] m_data_l;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data_l,
    output m_data_r,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data_l,
    input  m_data_r,
    input  m_last,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/i2s_capture_ctrl_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   push/push_data : write request; ignored when full unless a pop frees a slot.
//   pop            : consume head; ignored when empty (no bypass).
//   pop_data       : current head, stable until popped.
//   full/empty     : occupancy flags from the registered pointers.
module sync_fifo_fwft
  import i2s_capture_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH = 2 * AUDIO_DATA_WIDTH + 1,
  parameter  int unsigned DEPTH = AUDIO_FIFO_DEPTH,
  localparam int unsigned PTR_W = log2w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra wrap bit distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop   = pop && !empty;
  // A same-cycle pop frees the slot a full FIFO is about to reuse.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointers and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        wr_ptr_q                   <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// I2S capture sequencer: pairs left/right strobes into stereo frames, gates
// them into BLOCK_LEN-frame blocks on start/stop and queues them for the
// FFT/FIR loader with the last frame of each block flagged.
//   clk, rst_n          : sck-domain clock, async active-low reset.
//   start/stop          : arm / abort capture (stop wins).
//   continuous          : chain the next block when one completes.
//   rx_data/rx_l_vld/rx_r_vld : receiver sample and channel strobes.
//   m                   : frame stream (interface, master side).
//   busy, frame_cnt     : sequencer active, frames pushed in current block.
//   overrun, resync     : sticky drop / channel-order flags.
module i2s_capture_ctrl
  import i2s_capture_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter  int unsigned BLOCK_LEN  = AUDIO_BLOCK_LEN,
  parameter  int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  localparam int unsigned CNT_W      = log2w(BLOCK_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_l_vld,
  input  logic                  rx_r_vld,
  i2s_capture_ctrl_if.master    m,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  overrun,
  output logic                  resync
);

  localparam int unsigned     FRAME_W  = 2 * DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  cap_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  left_q, left_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   resync_q, resync_d;
  logic                   busy_q;

  logic                   push_c;
  logic                   push_last_c;
  logic                   pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FRAME_W-1:0]     fifo_head;

  assign pop_c = m.m_ready && !fifo_empty;

  // Next-state, frame formation and sticky-flag logic.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    resync_d    = resync_q;
    push_c      = 1'b0;
    push_last_c = 1'b0;

    if (stop && (state_q != ST_IDLE)) begin
      // Abort: any frame completing this cycle is dropped with the held left.
      state_d = ST_IDLE;
      left_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d   = ST_SYNC;
            cnt_d     = '0;
            overrun_d = 1'b0;
            resync_d  = 1'b0;
          end
        end

        // Blocks always begin on a left sample; stray rights are discarded.
        ST_SYNC: begin
          if (rx_l_vld) begin
            left_d  = rx_data;
            state_d = ST_WAIT_R;
            if (rx_r_vld) begin
              resync_d = 1'b1;
            end
          end
        end

        ST_WAIT_R: begin
          if (rx_l_vld) begin
            // Right missing (or both strobes): newest left replaces the held one.
            resync_d = 1'b1;
            left_d   = rx_data;
          end else if (rx_r_vld) begin
            push_c      = 1'b1;
            push_last_c = (cnt_q == LAST_IDX);
            cnt_d       = push_last_c ? '0 : cnt_q + CNT_W'(1);
            // Count advances even on a drop so block boundaries track the stream.
            if (fifo_full && !pop_c) begin
              overrun_d = 1'b1;
            end
            if (push_last_c && !continuous) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_L;
            end
          end
        end

        ST_WAIT_L: begin
          if (rx_l_vld) begin
            left_d  = rx_data;
            state_d = ST_WAIT_R;
            if (rx_r_vld) begin
              resync_d = 1'b1;
            end
          end else if (rx_r_vld) begin
            resync_d = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      left_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      resync_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      resync_q  <= resync_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Output frame queue; entry layout is {last, left, right}.
  sync_fifo_fwft #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data ({push_last_c, left_q, rx_data}),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m.m_valid                           = !fifo_empty;
  assign {m.m_last, m.m_data_l, m.m_data_r}  = fifo_head;

  assign busy      = busy_q;
  assign frame_cnt = cnt_q;
  assign overrun   = overrun_q;
  assign resync    = resync_q;

endmodule
